// File: rtl/dl_arb_pkg.sv
// Shared helpers for the register-file write arbiters.
// Index-width sizing and round-robin pointer arithmetic.
package dl_arb_pkg;

  function automatic int dl_id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dl_reg.sv
// Plain D register; reset and enable muxing live
// in the instantiating module's next-state logic.
module dl_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk) begin
    o_q <= i_d;
  end

endmodule

// File: rtl/dl_rr_pick.sv
// Combinational round-robin picker: first set request
// at or after the pointer, wrapping around.
module dl_rr_pick
  import dl_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = dl_id_bits(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_vld,
  output logic [IDW-1:0] o_idx,
  output logic [N-1:0]   o_gnt
);

  int w_j;

  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_idx      = IDW'(w_j);
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dl_rr_wr_arb.sv
// Round-robin arbiter sharing one register-file write
// port among NUM_REQ requesters, with a registered output.
module dl_rr_wr_arb
  import dl_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = dl_id_bits(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_val,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic                           wr_val,
  input  logic                           wr_rdy,
  output logic [ADDR_BITS-1:0]           wr_addr,
  output logic [DATA_BITS-1:0]           wr_data,
  output logic [ID_BITS-1:0]             wr_id
);

  logic [ID_BITS-1:0]   r_ptr;
  logic                 r_wr_val;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic [ID_BITS-1:0]   r_wr_id;

  logic [ID_BITS-1:0]   w_ptr_nxt;
  logic                 w_val_nxt;
  logic [ADDR_BITS-1:0] w_addr_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic [ID_BITS-1:0]   w_id_nxt;

  logic                 w_free;
  logic                 w_take;
  logic                 w_vld;
  logic [ID_BITS-1:0]   w_idx;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [DATA_BITS-1:0] w_sel_data;

  dl_rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_BITS)
  ) u_pick (
    .i_req (req_val),
    .i_ptr (r_ptr),
    .o_vld (w_vld),
    .o_idx (w_idx),
    .o_gnt (w_gnt)
  );

  // Draining and refilling in one edge keeps 1 write/cycle.
  assign w_free  = !r_wr_val || wr_rdy;
  assign w_take  = w_free && w_vld && !rst;
  assign req_rdy = w_gnt & {NUM_REQ{w_free && !rst}};

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_sel_addr
                   | req_addr[i*ADDR_BITS +: ADDR_BITS];
        w_sel_data = w_sel_data
                   | req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin
    w_ptr_nxt  = r_ptr;
    w_val_nxt  = r_wr_val;
    w_addr_nxt = r_wr_addr;
    w_data_nxt = r_wr_data;
    w_id_nxt   = r_wr_id;
    if (rst) begin
      w_ptr_nxt  = '0;
      w_val_nxt  = 1'b0;
      w_addr_nxt = '0;
      w_data_nxt = '0;
      w_id_nxt   = '0;
    end else if (w_take) begin
      w_ptr_nxt  = ID_BITS'(rr_next(int'(w_idx), NUM_REQ));
      w_val_nxt  = 1'b1;
      w_addr_nxt = w_sel_addr;
      w_data_nxt = w_sel_data;
      w_id_nxt   = w_idx;
    end else if (w_free) begin
      w_val_nxt  = 1'b0;
    end
  end

  dl_reg #(.W(ID_BITS)) u_ptr (
    .clk (clk), .i_d (w_ptr_nxt), .o_q (r_ptr)
  );

  dl_reg #(.W(1)) u_val (
    .clk (clk), .i_d (w_val_nxt), .o_q (r_wr_val)
  );

  dl_reg #(.W(ADDR_BITS)) u_addr (
    .clk (clk), .i_d (w_addr_nxt), .o_q (r_wr_addr)
  );

  dl_reg #(.W(DATA_BITS)) u_data (
    .clk (clk), .i_d (w_data_nxt), .o_q (r_wr_data)
  );

  dl_reg #(.W(ID_BITS)) u_id (
    .clk (clk), .i_d (w_id_nxt), .o_q (r_wr_id)
  );

  assign wr_val  = r_wr_val;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign wr_id   = r_wr_id;

endmodule
